// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered UART transmitter.
// Bytes pushed into a small circular FIFO are sent on tx, LSB first.
// The default frame is 8N1. Consecutive queued bytes go out as contiguous
// frames, with no idle cycle between a stop bit and the next start bit.
// Optional feature: define UART_TX_PARITY_EN for 8E1 framing. This adds an
// even-parity bit between the data bits and the stop bit.
module uart_tx_buf #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

  localparam logic [TW-1:0] TMR_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  // FIFO storage. It is never reset; only entries below count are read.
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Serialiser state.
  state_t          state;
  logic [TW-1:0]   tmr;
  logic [2:0]      idx;
  logic [7:0]      sh;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  // full is taken from the registered occupancy. A push while full is
  // therefore dropped, even if a pop frees a slot on the same edge.
  assign full    = (count == CNT_FULL);
  assign push    = wr_en && !full;
  assign bit_end = (tmr == TMR_LAST);
  assign busy    = (state != S_IDLE) || (count != '0);

  // Pop decision: leaving IDLE with data waiting, or chaining a new frame
  // straight out of the last stop-bit cycle.
  always_comb begin
    pop = 1'b0;
    if (count != '0) begin
      if (state == S_IDLE) begin
        pop = 1'b1;
      end else if ((state == S_STOP) && bit_end) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO write port (storage only, no reset).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at the depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame FSM. tx is registered from the next-state decode, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      tmr   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            sh    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
            tmr   <= '0;
            state <= S_START;
            tx    <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            tmr   <= '0;
            idx   <= '0;
            state <= S_DATA;
            tx    <= sh[0];
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            tmr <= '0;
            sh  <= {1'b0, sh[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              // The next data bit is the one about to shift into sh[0].
              tx <= sh[1];
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tmr   <= '0;
            state <= S_STOP;
            tx    <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            tmr <= '0;
            if (pop) begin
              // Back-to-back: the next start bit follows immediately.
              sh    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              par   <= ^mem[rd_ptr];
`endif
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          tmr   <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf with CLK_PER_BIT=4 and DEPTH_LOG2=2.
// A monitor decodes every frame on tx and checks it against a scoreboard
// queue. The queue is filled when bytes are driven.
module tb_uart_tx_buf;

  localparam int CPB = 4;
  localparam int DL2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           wr_en = 1'b0;
  logic [7:0]     wr_data = 8'h00;
  logic           full;
  logic [DL2:0]   count;
  logic           busy;
  logic           tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sb[$];
  int         start_q[$];
  logic       par_q[$];
  int         n_frames = 0;

  uart_tx_buf #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .busy(busy), .tx(tx)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame monitor
  logic [NBITS-1:0] mon_bits;
  logic             mon_glitch;
  logic             mon_abort;
  int               mon_st;
  logic [7:0]       mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        mon_st = cyc; mon_glitch = 1'b0; mon_abort = 1'b0; mon_bits = '0;
        for (int b = 0; b < NBITS; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (rstn !== 1'b1) mon_abort = 1'b1;
            if (c == 0) mon_bits[b] = tx;
            else if (tx !== mon_bits[b]) mon_glitch = 1'b1;
          end
        end
        if (!mon_abort) begin
          n_frames++;
          start_q.push_back(mon_st);
          checks++;
          if (mon_glitch !== 1'b0 || mon_bits[0] !== 1'b0 || mon_bits[NBITS-1] !== 1'b1) begin
            errors++;
            $display("FAIL frame_shape: start=%b stop=%b glitch=%b at cycle %0d, required start=0 stop=1 glitch=0",
                     mon_bits[0], mon_bits[NBITS-1], mon_glitch, mon_st);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got byte %02h at cycle %0d, required no frame", mon_bits[8:1], mon_st);
          end else begin
            mon_exp = sb.pop_front();
            if (mon_bits[8:1] !== mon_exp) begin
              errors++;
              $display("FAIL frame_data: got %02h, required %02h (cycle %0d)", mon_bits[8:1], mon_exp, mon_st);
            end
`ifdef UART_TX_PARITY_EN
            par_q.push_back(mon_bits[9]);
            checks++;
            if (mon_bits[9] !== ^mon_exp) begin
              errors++;
              $display("FAIL frame_parity: got %b, required %b for byte %02h", mon_bits[9], ^mon_exp, mon_exp);
            end
`endif
          end
          $display("frame at cycle %0d: byte %02h", mon_st, mon_bits[8:1]);
        end
      end
    end
  end

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    fall_cyc = cyc;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic push_burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      wr_en = 1'b1;
      wr_data = bytes[i];
      sb.push_back(bytes[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (tx !== 1'b1 || full !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b full=%b count=%0d busy=%b, required 1 0 0 0", tx, full, count, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_single;
    int n, f;
    start_q.delete();
    wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    n = cyc;
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL single_count_after_push: got %0d, required 1", count);
    end
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || tx !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: count=%0d tx=%b, required 0 0", count, tx);
    end
    wait_idle(200, f);
    checks++;
    if (f != n + FRAME + 1) begin
      errors++;
      $display("FAIL single_busy_fall: got cycle %0d, required %0d", f, n + FRAME + 1);
    end
    checks++;
    if (start_q.size() != 1 || (start_q.size() == 1 && start_q[0] != n + 1)) begin
      errors++;
      $display("FAIL single_start: frames=%0d first start=%0d, required 1 at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, n + 1);
    end
    $display("single byte pushed at cycle %0d, busy fell at %0d", n, f);
  endtask

  task automatic test_back_to_back;
    int f;
    start_q.delete();
    push_burst('{8'h00, 8'hFF});
    wait_idle(300, f);
    checks++;
    if (start_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames, required 2", start_q.size());
    end else begin
      checks++;
      if (start_q[1] - start_q[0] != FRAME) begin
        errors++;
        $display("FAIL b2b_gap: got %0d cycles, required %0d", start_q[1] - start_q[0], FRAME);
      end
      checks++;
      if (f - start_q[0] != 2 * FRAME) begin
        errors++;
        $display("FAIL b2b_busy: got %0d cycles, required %0d", f - start_q[0], 2 * FRAME);
      end
    end
    $display("back-to-back done at cycle %0d", f);
  endtask

  task automatic test_full_drop;
    logic [7:0] d[6]    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int         ecnt[6] = '{1, 1, 2, 3, 4, 4};
    logic       efull[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int f, n, frames0;
    frames0 = n_frames;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = d[i];
      if (i < 5) sb.push_back(d[i]);
      @(negedge clk);
      checks++;
      if (count !== ecnt[i][DL2:0] || full !== efull[i]) begin
        errors++;
        $display("FAIL full_step%0d: count=%0d full=%b, required %0d %b", i, count, full, ecnt[i], efull[i]);
      end
    end
    wr_en = 1'b0;
    n = 0;
    while (full === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (full !== 1'b0 || count !== 3'd3) begin
      errors++;
      $display("FAIL full_release: full=%b count=%0d, required 0 3", full, count);
    end
    wait_idle(600, f);
    checks++;
    if (n_frames - frames0 != 5 || sb.size() != 0) begin
      errors++;
      $display("FAIL full_frames: got %0d frames, %0d left, required 5 and 0", n_frames - frames0, sb.size());
    end
    $display("full/drop done at cycle %0d", f);
  endtask

  task automatic test_wrap;
    int f, frames0;
    frames0 = n_frames;
    push_burst('{8'h01, 8'h02, 8'h03});
    wait_idle(400, f);
    push_burst('{8'h04, 8'h05, 8'h06, 8'h07});
    wait_idle(400, f);
    push_burst('{8'h08, 8'h09, 8'h0A});
    wait_idle(400, f);
    checks++;
    if (n_frames - frames0 != 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_frames: got %0d frames, %0d left, required 10 and 0", n_frames - frames0, sb.size());
    end
    $display("wrap done at cycle %0d", f);
  endtask

  task automatic test_reset_mid;
    int frames0;
    logic bad;
    wr_en = 1'b1; wr_data = 8'h3C; sb.push_back(8'h3C);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: tx=%b count=%0d busy=%b, required 1 0 0", tx, count, busy);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    frames0 = n_frames;
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || n_frames != frames0) begin
      errors++;
      $display("FAIL reset_quiet: activity=%b frames=%0d, required 0 0", bad, n_frames - frames0);
    end
    $display("reset mid-frame done at cycle %0d", cyc);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int f;
    start_q.delete();
    par_q.delete();
    push_burst('{8'h07, 8'h03});
    wait_idle(300, f);
    checks++;
    if (start_q.size() != 2 || par_q.size() != 2) begin
      errors++;
      $display("FAIL parity_frames: got %0d frames, required 2", start_q.size());
    end else begin
      checks++;
      if (par_q[0] !== 1'b1 || par_q[1] !== 1'b0) begin
        errors++;
        $display("FAIL parity_bits: got %b %b, required 1 0", par_q[0], par_q[1]);
      end
      checks++;
      if (start_q[1] - start_q[0] != 44) begin
        errors++;
        $display("FAIL parity_len: got %0d cycles, required 44", start_q[1] - start_q[0]);
      end
    end
    $display("parity done at cycle %0d", f);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_drop();
    test_wrap();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
